// File: rtl/mfdfa_pkg.sv
// Shared defaults and the dispatcher FSM encoding for the chunk dispatch block.
package mfdfa_pkg;

    localparam int DEF_W  = 32;
    localparam int DEF_NQ = 3;
    localparam int DEF_NW = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } disp_state_e;

endpackage

// File: rtl/chunk_dispatch_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found searching upward (with wrap) from the pointer.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    // Walk from the pointer, wrapping modulo N, and grant the first request seen.
    always_comb begin
        int   idx;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chunk_dispatch.sv
// Chunk dispatcher: pulls jobs from NQ queue heads round-robin and hands each
// to the lowest idle worker; malformed heads (end < start) are discarded.
module chunk_dispatch
    import mfdfa_pkg::*;
#(
    parameter int NQ = DEF_NQ,
    parameter int NW = DEF_NW,
    parameter int W  = DEF_W
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            en,
    input  logic [NQ-1:0]   q_valid,
    input  logic [NQ*W-1:0] q_si,
    input  logic [NQ*W-1:0] q_ei,
    input  logic [NQ*W-1:0] q_id,
    output logic [NQ-1:0]   q_pop,
    output logic [NW-1:0]   w_start,
    output logic [NW*W-1:0] w_si,
    output logic [NW*W-1:0] w_ei,
    output logic [NW*W-1:0] w_id,
    input  logic [NW-1:0]   w_done,
    output logic [NW-1:0]   busy,
    output logic [1:0]      state_o,
    output logic            drained,
    output logic [W-1:0]    jobs_issued,
    output logic [W-1:0]    jobs_done,
    output logic            bad_job,
    output logic            err_done
);

    localparam int QPW = (NQ > 1) ? $clog2(NQ) : 1;

    disp_state_e    state_q, state_d;
    logic [QPW-1:0] rr_q, rr_d;
    logic [NQ-1:0]  q_pop_q, q_pop_d;   // also the grant of the previous edge
    logic [NQ-1:0]  pop_dly_q;          // grant of the edge before that
    logic [NW-1:0]  w_start_q, w_start_d;
    logic [NW-1:0]  busy_q, busy_d;
    logic [W-1:0]   issued_q, issued_d, done_q, done_d;
    logic           bad_q, bad_d, err_q, err_d, drained_q, drained_d;
    logic [W-1:0]   w_si_q [NW];
    logic [W-1:0]   w_ei_q [NW];
    logic [W-1:0]   w_id_q [NW];

    logic [NQ-1:0]  eligible, arb_gnt, grant;
    logic [NW-1:0]  free_oh, done_ok;
    logic           free_any;
    logic [QPW-1:0] gnt_idx;
    logic [W-1:0]   head_si, head_ei, head_id, done_add;

    // A queue just popped needs two edges for its head to settle.
    assign eligible = q_valid & ~q_pop_q & ~pop_dly_q;
    assign done_ok  = w_done & busy_q;

    rr_arbiter #(.N(NQ), .PW(QPW)) u_rr_arbiter (
        .req_i (eligible),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt)
    );

    // Pick the lowest-index idle worker as the target of any dispatch.
    always_comb begin
        free_oh  = '0;
        free_any = 1'b0;
        for (int j = 0; j < NW; j++) begin
            if (!busy_q[j] && !free_any) begin
                free_oh[j] = 1'b1;
                free_any   = 1'b1;
            end
        end
    end

    // Qualify the arbiter grant and mux out the granted queue head.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        head_si = '0;
        head_ei = '0;
        head_id = '0;
        if (state_q == ST_RUN && en && free_any) begin
            grant = arb_gnt;
        end
        for (int k = 0; k < NQ; k++) begin
            if (grant[k]) begin
                gnt_idx = QPW'(k);
                head_si = q_si[k*W +: W];
                head_ei = q_ei[k*W +: W];
                head_id = q_id[k*W +: W];
            end
        end
    end

    // Next-state logic: FSM transitions, dispatch bookkeeping, completions.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        q_pop_d   = grant;
        w_start_d = '0;
        issued_d  = issued_q;
        bad_d     = bad_q;
        done_add  = '0;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (en) state_d = ST_RUN;
                else if (busy_q == '0) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        if (|grant) begin
            rr_d = (gnt_idx == QPW'(NQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (head_ei < head_si) begin
                bad_d = 1'b1;
            end else begin
                w_start_d = free_oh;
                issued_d  = issued_q + 1'b1;
            end
        end
        for (int j = 0; j < NW; j++) begin
            done_add = done_add + W'(done_ok[j]);
        end
        done_d    = done_q + done_add;
        err_d     = err_q | (|(w_done & ~busy_q));
        busy_d    = (busy_q & ~done_ok) | w_start_d;
        drained_d = (q_valid == '0) && (busy_d == '0) && (q_pop_d == '0);
    end

    // Control, status and counter registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            q_pop_q   <= '0;
            pop_dly_q <= '0;
            w_start_q <= '0;
            busy_q    <= '0;
            issued_q  <= '0;
            done_q    <= '0;
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
            drained_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            q_pop_q   <= q_pop_d;
            pop_dly_q <= q_pop_q;
            w_start_q <= w_start_d;
            busy_q    <= busy_d;
            issued_q  <= issued_d;
            done_q    <= done_d;
            bad_q     <= bad_d;
            err_q     <= err_d;
            drained_q <= drained_d;
        end
    end

    for (genvar gi = 0; gi < NW; gi++) begin : g_worker
        // Capture the head when this worker is started; hold it until reassigned.
        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                w_si_q[gi] <= '0;
                w_ei_q[gi] <= '0;
                w_id_q[gi] <= '0;
            end else if (w_start_d[gi]) begin
                w_si_q[gi] <= head_si;
                w_ei_q[gi] <= head_ei;
                w_id_q[gi] <= head_id;
            end
        end
        assign w_si[gi*W +: W] = w_si_q[gi];
        assign w_ei[gi*W +: W] = w_ei_q[gi];
        assign w_id[gi*W +: W] = w_id_q[gi];
    end

    assign q_pop       = q_pop_q;
    assign w_start     = w_start_q;
    assign busy        = busy_q;
    assign state_o     = state_q;
    assign drained     = drained_q;
    assign jobs_issued = issued_q;
    assign jobs_done   = done_q;
    assign bad_job     = bad_q;
    assign err_done    = err_q;

endmodule

// File: tb/tb_chunk_dispatch.sv
// Self-checking bench for chunk_dispatch: queue/worker environment plus a
// transaction-level reference model of the dispatcher.
`timescale 1ns/1ps
module tb_chunk_dispatch;

    localparam int NQ = 3;
    localparam int NW = 3;
    localparam int W  = 32;
    localparam int VW = NQ + 2*NW + 5;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            en;
    logic [NQ-1:0]   q_valid;
    logic [NQ*W-1:0] q_si, q_ei, q_id;
    logic [NQ-1:0]   q_pop;
    logic [NW-1:0]   w_start;
    logic [NW*W-1:0] w_si, w_ei, w_id;
    logic [NW-1:0]   w_done;
    logic [NW-1:0]   busy;
    logic [1:0]      state_o;
    logic            drained;
    logic [W-1:0]    jobs_issued, jobs_done;
    logic            bad_job, err_done;

    chunk_dispatch #(.NQ(NQ), .NW(NW), .W(W)) dut (
        .Clk(Clk), .Rst(Rst), .en(en), .q_valid(q_valid),
        .q_si(q_si), .q_ei(q_ei), .q_id(q_id), .q_pop(q_pop),
        .w_start(w_start), .w_si(w_si), .w_ei(w_ei), .w_id(w_id),
        .w_done(w_done), .busy(busy), .state_o(state_o), .drained(drained),
        .jobs_issued(jobs_issued), .jobs_done(jobs_done),
        .bad_job(bad_job), .err_done(err_done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [W-1:0] si;
        logic [W-1:0] ei;
        logic [W-1:0] id;
    } job_t;

    // Environment: job queues and worker completion timers.
    job_t          qmem [NQ][64];
    int            qh [NQ];
    int            qt [NQ];
    int            timer [NW];
    int            lat_mode;      // 0 never completes, 1 one cycle, 2 random 1..6
    logic [NW-1:0] force_done;
    int            cyc;

    // Reference model state.
    int            m_state, m_rr, m_g1, m_g2;
    logic [NQ-1:0] m_pop;
    logic [NW-1:0] m_start, m_busy;
    logic [W-1:0]  m_wsi [NW];
    logic [W-1:0]  m_wei [NW];
    logic [W-1:0]  m_wid [NW];
    logic [W-1:0]  m_issued, m_done;
    logic          m_bad, m_err, m_drained;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [VW-1:0] exp_vec();
        return {m_pop, m_start, m_busy, 2'(m_state), m_drained, m_bad, m_err};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {q_pop, w_start, busy, state_o, drained, bad_job, err_done};
    endfunction

    function automatic logic [3*NW*W-1:0] exp_w();
        logic [3*NW*W-1:0] v;
        v = '0;
        for (int j = 0; j < NW; j++) begin
            v[j*W +: W]        = m_wsi[j];
            v[(NW+j)*W +: W]   = m_wei[j];
            v[(2*NW+j)*W +: W] = m_wid[j];
        end
        return v;
    endfunction

    function automatic logic [3*NW*W-1:0] act_w();
        return {w_id, w_ei, w_si};
    endfunction

    task automatic model_reset();
        m_state = 0; m_rr = 0; m_g1 = -1; m_g2 = -1;
        m_pop = '0; m_start = '0; m_busy = '0;
        for (int j = 0; j < NW; j++) begin
            m_wsi[j] = '0; m_wei[j] = '0; m_wid[j] = '0;
        end
        m_issued = '0; m_done = '0;
        m_bad = 1'b0; m_err = 1'b0; m_drained = 1'b1;
    endtask

    task automatic push(input int k, input logic [W-1:0] si, input logic [W-1:0] ei,
                        input logic [W-1:0] id);
        qmem[k][qt[k] % 64] = '{si: si, ei: ei, id: id};
        qt[k]++;
    endtask

    task automatic drive_inputs();
        job_t h;
        for (int k = 0; k < NQ; k++) begin
            if (qt[k] > qh[k]) begin
                h = qmem[k][qh[k] % 64];
                q_valid[k] = 1'b1;
                q_si[k*W +: W] = h.si;
                q_ei[k*W +: W] = h.ei;
                q_id[k*W +: W] = h.id;
            end else begin
                q_valid[k] = 1'b0;
                q_si[k*W +: W] = '0;
                q_ei[k*W +: W] = '0;
                q_id[k*W +: W] = '0;
            end
        end
        for (int j = 0; j < NW; j++) begin
            w_done[j] = (timer[j] == 1) | force_done[j];
        end
    endtask

    // Spec-level behaviour of one rising edge, from the current inputs.
    task automatic model_edge();
        int ns, ksel, jsel, k;
        logic [NW-1:0] ok;
        logic [W-1:0] hs, he, hid;
        ns = m_state;
        case (m_state)
            0: if (en) ns = 1;
            1: if (!en) ns = 2;
            default: if (en) ns = 1; else if (m_busy == '0) ns = 0;
        endcase
        ksel = -1;
        jsel = -1;
        if (m_state == 1 && en) begin
            for (int j = NW - 1; j >= 0; j--) if (!m_busy[j]) jsel = j;
            for (int i = 0; i < NQ; i++) begin
                k = (m_rr + i) % NQ;
                if (ksel < 0 && q_valid[k] && k != m_g1 && k != m_g2) ksel = k;
            end
            if (jsel < 0) ksel = -1;
        end
        m_pop = '0;
        m_start = '0;
        ok = w_done & m_busy;
        if ((w_done & ~m_busy) != '0) m_err = 1'b1;
        for (int j = 0; j < NW; j++) if (ok[j]) m_done++;
        m_busy = m_busy & ~ok;
        if (ksel >= 0) begin
            hs = q_si[ksel*W +: W];
            he = q_ei[ksel*W +: W];
            hid = q_id[ksel*W +: W];
            m_pop[ksel] = 1'b1;
            m_rr = (ksel + 1) % NQ;
            if (he < hs) begin
                m_bad = 1'b1;
                $display("cyc=%0d reject q%0d si=%0d ei=%0d", cyc, ksel, hs, he);
            end else begin
                m_start[jsel] = 1'b1;
                m_busy[jsel] = 1'b1;
                m_wsi[jsel] = hs; m_wei[jsel] = he; m_wid[jsel] = hid;
                m_issued++;
                $display("cyc=%0d grant q%0d -> worker %0d id=%0d", cyc, ksel, jsel, hid);
            end
        end
        m_g2 = m_g1;
        m_g1 = ksel;
        m_state = ns;
        m_drained = (q_valid == '0) && (m_busy == '0) && (m_pop == '0);
    endtask

    // Advance one clock: model the edge, then let queues/workers react.
    task automatic tick();
        logic [NQ-1:0] pop_now;
        drive_inputs();
        pop_now = m_pop;
        model_edge();
        @(posedge Clk);
        #1;
        cyc++;
        for (int k = 0; k < NQ; k++) if (pop_now[k]) qh[k]++;
        force_done = '0;
        for (int j = 0; j < NW; j++) begin
            if (timer[j] > 0) timer[j]--;
            if (m_start[j]) timer[j] = (lat_mode == 0) ? 0 :
                                       (lat_mode == 1) ? 1 : int'($urandom_range(1, 6));
        end
        drive_inputs();
    endtask

    task automatic clear_env();
        en = 1'b0;
        force_done = '0;
        for (int k = 0; k < NQ; k++) begin qh[k] = 0; qt[k] = 0; end
        for (int j = 0; j < NW; j++) timer[j] = 0;
        drive_inputs();
    endtask

    task automatic apply_reset();
        clear_env();
        Rst = 1'b0;
        model_reset();
        #12;
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_env();
        Rst = 1'b1;
        @(negedge Clk);
        #2 Rst = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_ctrl act=%h exp=%h", act_vec(), exp_vec());
        end
        n_chk++;
        if ({jobs_issued, jobs_done} !== {m_issued, m_done}) begin
            n_fail++; $display("FAIL reset_cnt act=%h exp=%h", {jobs_issued, jobs_done}, {m_issued, m_done});
        end
        n_chk++;
        if (act_w() !== exp_w()) begin
            n_fail++; $display("FAIL reset_wregs act=%h exp=%h", act_w(), exp_w());
        end
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_single_job();
        apply_reset();
        lat_mode = 0;
        push(0, 32'd0, 32'd9, 32'd5);
        en = 1'b1;
        tick();
        n_chk++;
        if (state_o !== 2'b01 || q_pop !== 3'b000) begin
            n_fail++; $display("FAIL single_to_run act=%b/%b exp=01/000", state_o, q_pop);
        end
        tick();
        n_chk++;
        if ({q_pop, w_start, busy} !== 9'b001_001_001 || w_id[W-1:0] !== 32'd5 || jobs_issued !== 32'd1) begin
            n_fail++; $display("FAIL single_grant act=%b id=%0d iss=%0d exp=001001001 id=5 iss=1",
                               {q_pop, w_start, busy}, w_id[W-1:0], jobs_issued);
        end
        tick();
        n_chk++;
        if (act_vec() !== exp_vec() || {q_pop, w_start} !== 6'b0) begin
            n_fail++; $display("FAIL single_pulse act=%h exp=%h", act_vec(), exp_vec());
        end
        force_done = 3'b001;
        tick();
        n_chk++;
        if (busy !== 3'b000 || jobs_done !== 32'd1 || drained !== 1'b1 || w_id[W-1:0] !== 32'd5) begin
            n_fail++; $display("FAIL single_done act=busy%b done%0d drained%b id%0d exp=busy000 done1 drained1 id5",
                               busy, jobs_done, drained, w_id[W-1:0]);
        end
        n_chk++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL single_model act=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_fairness();
        int last [NQ];
        int cnt [NQ];
        int nexp;
        apply_reset();
        lat_mode = 1;
        for (int k = 0; k < NQ; k++) begin
            last[k] = -100; cnt[k] = 0;
            for (int n = 0; n < 4; n++) begin
                logic [W-1:0] s;
                s = W'($urandom_range(0, 500));
                push(k, s, s + W'($urandom_range(0, 50)), W'(k*10 + n));
            end
        end
        nexp = 0;
        en = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            n_chk++;
            if (act_vec() !== exp_vec() || act_w() !== exp_w()) begin
                n_fail++; $display("FAIL fair_cycle cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            for (int k = 0; k < NQ; k++) begin
                if (q_pop[k]) begin
                    n_chk++;
                    if (k !== nexp % NQ || cyc - last[k] <= 2) begin
                        n_fail++; $display("FAIL fair_order cyc=%0d act=q%0d gap=%0d exp=q%0d gap>2",
                                           cyc, k, cyc - last[k], nexp % NQ);
                    end
                    nexp++; cnt[k]++; last[k] = cyc;
                end
            end
        end
        for (int k = 0; k < NQ; k++) begin
            n_chk++;
            if (cnt[k] !== 4) begin
                n_fail++; $display("FAIL fair_count q%0d act=%0d exp=4", k, cnt[k]);
            end
        end
        n_chk++;
        if (jobs_issued !== 32'd12 || jobs_done !== 32'd12) begin
            n_fail++; $display("FAIL fair_totals act=%0d/%0d exp=12/12", jobs_issued, jobs_done);
        end
    endtask

    task automatic test_backpressure();
        int starts;
        apply_reset();
        lat_mode = 0;
        for (int n = 0; n < 3; n++) push(0, W'(n), W'(n + 4), W'(100 + n));
        for (int n = 0; n < 2; n++) push(1, W'(n), W'(n + 4), W'(200 + n));
        en = 1'b1;
        starts = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            starts += $countones(w_start);
            n_chk++;
            if (act_vec() !== exp_vec() || act_w() !== exp_w()) begin
                n_fail++; $display("FAIL bp_cycle cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        n_chk++;
        if (starts !== 3 || busy !== 3'b111) begin
            n_fail++; $display("FAIL bp_starts act=%0d busy=%b exp=3 busy=111", starts, busy);
        end
        force_done = 3'b010;
        tick();
        n_chk++;
        if (busy !== 3'b101) begin
            n_fail++; $display("FAIL bp_release act=%b exp=101", busy);
        end
        tick();
        n_chk++;
        if (w_start !== 3'b010 || act_vec() !== exp_vec() || w_id[W +: W] !== m_wid[1]) begin
            n_fail++; $display("FAIL bp_reuse act=%b id=%0d exp=010 id=%0d", w_start, w_id[W +: W], m_wid[1]);
        end
    endtask

    task automatic test_bad_job();
        apply_reset();
        lat_mode = 0;
        push(0, 32'd0, 32'd4, 32'd1);
        push(1, 32'd20, 32'd10, 32'd9);
        en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL bad_cycle cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        n_chk++;
        if (bad_job !== 1'b1 || jobs_issued !== 32'd1 || busy !== 3'b001 || q_valid !== 3'b000) begin
            n_fail++; $display("FAIL bad_result act=bad%b iss%0d busy%b qv%b exp=bad1 iss1 busy001 qv000",
                               bad_job, jobs_issued, busy, q_valid);
        end
    endtask

    task automatic test_drain_reset();
        apply_reset();
        lat_mode = 0;
        push(0, 32'd1, 32'd2, 32'd11);
        push(1, 32'd3, 32'd4, 32'd12);
        en = 1'b1;
        repeat (5) tick();
        n_chk++;
        if (busy !== 3'b011) begin
            n_fail++; $display("FAIL drain_setup act=%b exp=011", busy);
        end
        en = 1'b0;
        push(2, 32'd5, 32'd6, 32'd13);
        push(0, 32'd7, 32'd8, 32'd14);
        for (int c = 0; c < 4; c++) begin
            tick();
            n_chk++;
            if (state_o !== 2'b10 || q_pop !== 3'b000 || act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL drain_hold act=st%b pop%b exp=st10 pop000", state_o, q_pop);
            end
        end
        force_done = 3'b011;
        tick();
        tick();
        n_chk++;
        if (state_o !== 2'b00 || busy !== 3'b000 || jobs_done !== 32'd2) begin
            n_fail++; $display("FAIL drain_idle act=st%b busy%b done%0d exp=st00 busy000 done2",
                               state_o, busy, jobs_done);
        end
        en = 1'b1;
        repeat (3) tick();
        #3 Rst = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (act_vec() !== exp_vec() || {jobs_issued, jobs_done} !== 64'd0 || act_w() !== exp_w()) begin
            n_fail++; $display("FAIL async_reset act=%h exp=%h", act_vec(), exp_vec());
        end
        clear_env();
        @(negedge Clk);
        Rst = 1'b1;
        force_done = 3'b100;
        tick();
        n_chk++;
        if (err_done !== 1'b1 || busy !== 3'b000 || jobs_done !== 32'd0) begin
            n_fail++; $display("FAIL spurious_done act=err%b busy%b done%0d exp=err1 busy000 done0",
                               err_done, busy, jobs_done);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] s;
        apply_reset();
        lat_mode = 2;
        en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NQ; k++) begin
                if ($urandom_range(0, 3) == 0 && qt[k] - qh[k] < 8) begin
                    s = W'($urandom_range(1, 1000));
                    if ($urandom_range(0, 7) == 0) push(k, s, s - W'($urandom_range(1, 9)), W'($urandom));
                    else push(k, s, s + W'($urandom_range(0, 99)), W'($urandom));
                end
            end
            if ($urandom_range(0, 24) == 0) en = ~en;
            if ($urandom_range(0, 149) == 0) force_done[$urandom_range(0, NW - 1)] = 1'b1;
            tick();
            n_chk++;
            if (act_vec() !== exp_vec() || act_w() !== exp_w() ||
                {jobs_issued, jobs_done} !== {m_issued, m_done}) begin
                n_fail++; $display("FAIL rand_cycle cyc=%0d act=%h/%0d/%0d exp=%h/%0d/%0d", cyc,
                                   act_vec(), jobs_issued, jobs_done, exp_vec(), m_issued, m_done);
            end
        end
    endtask

    initial begin
        Rst = 1'b0;
        en = 1'b0;
        w_done = '0;
        q_valid = '0;
        q_si = '0; q_ei = '0; q_id = '0;
        cyc = 0;
        lat_mode = 0;
        model_reset();
        clear_env();
        #20;
        test_reset();
        test_single_job();
        test_fairness();
        test_backpressure();
        test_bad_job();
        test_drain_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/chunk_dispatch.md
CHUNK_DISPATCH -- requirements
Module: chunk_dispatch

Interface
REQ-001 Parameter NQ, default 3, number of chunk-job queues.
REQ-002 Parameter NW, default 3, number of iterator workers.
REQ-003 Parameter W, default 32, index/id width.
REQ-004 Clk  input  1  clock; all state changes on rising edge.
REQ-005 Rst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  enables dispatch of new jobs.
REQ-007 q_valid  input  NQ  queue k head holds a job.
REQ-008 q_si, q_ei, q_id  input  NQ*W each  head start index, end index, chunk id; slice k = queue k.
REQ-009 q_pop  output  NQ  one-cycle pop pulse to queue k.
REQ-010 w_start  output  NW  one-cycle start pulse to worker j.
REQ-011 w_si, w_ei, w_id  output  NW*W each  job held for worker j while busy.
REQ-012 w_done  input  NW  one-cycle completion pulse from worker j.
REQ-013 busy  output  NW  worker j owns a job.
REQ-014 state_o  output  2  current FSM state.
REQ-015 drained  output  1  no job queued, pending or running.
REQ-016 jobs_issued, jobs_done  output  W each  wrapping job counters.
REQ-017 bad_job, err_done  output  1 each  sticky error flags.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 FSM states: IDLE(00), RUN(01), DRAIN(10); IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->IDLE when busy==0; DRAIN->RUN when en=1.
REQ-020 Dispatch SHALL occur only in RUN, at most one job per edge.
REQ-021 Queue k is eligible when q_valid[k]=1 and k was not granted on either of the two preceding edges (pop-settle blackout).
REQ-022 Queue selection SHALL be round-robin: search upward from pointer rr, modulo NQ; after granting k, rr <= (k+1) mod NQ; rr unchanged when no grant.
REQ-023 Worker selection SHALL be lowest-index j with busy[j]=0; no grant if all workers busy (queue head left untouched, no pop).
REQ-024 On grant at edge t: q_pop[k]=1 and w_start[j]=1 during cycle t+1 only; w_si/w_ei/w_id[j] capture head at edge t; busy[j]=1 from t+1; jobs_issued increments.
REQ-025 A head with q_ei < q_si SHALL be popped (same timing), not issued, no worker consumed, bad_job set; rr advances.
REQ-026 w_done[j] with busy[j]=1 SHALL clear busy[j] at that edge; worker j becomes selectable on the next edge, not the same edge.
REQ-027 jobs_done SHALL add popcount of valid done pulses per edge (simultaneous completions all counted).
REQ-028 w_done[j] with busy[j]=0 SHALL set err_done and be ignored otherwise.
REQ-029 drained = 1 when q_valid==0, busy==0 and no q_pop pulse in flight.
REQ-030 Counters wrap modulo 2^W without flagging.
REQ-031 w_si/w_ei/w_id[j] SHALL hold after completion until next assignment to j.

Reset
REQ-032 Rst low SHALL immediately force: state IDLE, rr=0, blackout cleared, q_pop=0, w_start=0, busy=0, w_si/w_ei/w_id=0, counters=0, bad_job=0, err_done=0, drained=1.
REQ-033 Reset mid-operation abandons running jobs; w_done pulses in the first cycle after release are treated per REQ-028.

Structure
REQ-034 Package mfdfa_pkg SHALL hold W, NQ/NW defaults, and the FSM state encodings.
REQ-035 One sub-module rr_arbiter (NQ-wide request, pointer in, one-hot grant out, combinational) SHALL be instantiated; the rest is flat.

Verification
REQ-036 Single job: q_valid=001, si=0, ei=9, id=5, en=1 -> q_pop[0] and w_start[0] pulse one cycle, w_id[0]=5, busy=001, jobs_issued=1; w_done[0] -> busy=000, jobs_done=1, drained=1.
REQ-037 Fairness: all three queues hold 4 jobs, workers complete 1 cycle after start -> grants cycle q0,q1,q2,q0,...; each queue popped exactly 4 times, never on consecutive or next-but-one edges.
REQ-038 Backpressure: 5 jobs queued, workers never done -> exactly 3 starts (workers 0,1,2), no further pops; w_done[1] -> next job goes to worker 1.
REQ-039 Bad job: head si=20, ei=10 -> popped, bad_job=1, jobs_issued unchanged, busy unchanged.
REQ-040 Drain and reset: en dropped with busy=011 -> state DRAIN, no pops; both done -> IDLE; then Rst low mid-RUN -> all outputs at REQ-032 values asynchronously, spurious w_done after release sets err_done.
